dcache_mem_ctrl: RTL and testbench



---
 rtl/dcache_pkg.sv | 24 ++
 rtl/dcache_mem_array.sv | 36 +++
 rtl/dcache_mem_ctrl.sv | 151 +++++++++++++++
 tb/tb_dcache_mem_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared constants and types for the data cache and its backing memory controller.
package dcache_pkg;

   localparam int LINE_W     = 256;
   localparam int OFFSET_W   = 5;
   localparam int LINE_BYTES = LINE_W / 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      logic [31:0] r;
      if (v == 32'hFFFF_FFFF) begin
         r = v;
      end else begin
         r = v + 32'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/dcache_mem_array.sv
// Synchronous line RAM; read data is registered only on a read access and held otherwise.
module dcache_mem_array #(
   parameter int LINE_W = 256,
   parameter int DEPTH  = 1024,
   parameter int IDX_W  = $clog2(DEPTH)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              en_i,
   input  logic              we_i,
   input  logic [IDX_W-1:0]  idx_i,
   input  logic [LINE_W-1:0] wdata_i,
   output logic [LINE_W-1:0] rdata_o
);

   logic [LINE_W-1:0] mem_q [DEPTH];
   logic [LINE_W-1:0] rdata_q;

   // Storage is never cleared by reset.
   always_ff @(posedge clk_i) begin
      if (en_i && we_i) begin
         mem_q[idx_i] <= wdata_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rdata_q <= '0;
      end else if (en_i && !we_i) begin
         rdata_q <= mem_q[idx_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/dcache_mem_ctrl.sv
// Line memory controller behind the data cache: fixed-latency ack, one turnaround cycle.
// Optional read/write completion counters are built when DCACHE_MEM_STATS_EN is defined.
module dcache_mem_ctrl
   import dcache_pkg::*;
#(
   parameter int LINE_W  = dcache_pkg::LINE_W,
   parameter int ADDR_W  = 32,
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 10
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [LINE_W-1:0] data_i,
   input  logic              enable_i,
   input  logic              write_i,
   output logic              ack_o,
   output logic [LINE_W-1:0] data_o,
   output logic [31:0]       rd_cnt_o,
   output logic [31:0]       wr_cnt_o
);

   localparam int         IDX_W  = $clog2(DEPTH);
   localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

   state_e            state_q, state_d;
   logic [7:0]        cnt_q, cnt_d;
   logic              ack_q, ack_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [LINE_W-1:0] wdata_q, wdata_d;
   logic              write_q, write_d;
   logic              ram_en_s;
   logic              ram_we_s;
   logic [LINE_W-1:0] ram_rdata_s;
   logic              unused_addr_s;

   assign unused_addr_s = ^{addr_i[ADDR_W-1:OFFSET_W+IDX_W], addr_i[OFFSET_W-1:0]};

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      ack_d    = 1'b0;
      idx_d    = idx_q;
      wdata_d  = wdata_q;
      write_d  = write_q;
      ram_en_s = 1'b0;
      ram_we_s = 1'b0;
      case (state_q)
         IDLE: begin
            if (enable_i) begin
               idx_d   = addr_i[OFFSET_W +: IDX_W];
               wdata_d = data_i;
               write_d = write_i;
               cnt_d   = LAT_M1;
               state_d = BUSY;
            end else begin
               state_d = IDLE;
            end
         end
         BUSY: begin
            if (cnt_q == 8'd0) begin
               ack_d    = 1'b1;
               // A reset on the completing edge must not commit the write.
               ram_en_s = ~rst_i;
               ram_we_s = write_q;
               state_d  = DONE;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= 8'd0;
         ack_q   <= 1'b0;
         idx_q   <= '0;
         wdata_q <= '0;
         write_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ack_q   <= ack_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         write_q <= write_d;
      end
   end

   dcache_mem_array #(
      .LINE_W (LINE_W),
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W)
   ) u_array (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .en_i    (ram_en_s),
      .we_i    (ram_we_s),
      .idx_i   (idx_q),
      .wdata_i (wdata_q),
      .rdata_o (ram_rdata_s)
   );

   assign ack_o  = ack_q;
   assign data_o = ram_rdata_s;

`ifdef DCACHE_MEM_STATS_EN
   logic [31:0] rd_cnt_q, rd_cnt_d;
   logic [31:0] wr_cnt_q, wr_cnt_d;

   always_comb begin
      rd_cnt_d = rd_cnt_q;
      wr_cnt_d = wr_cnt_q;
      if (ram_en_s && !ram_we_s) begin
         rd_cnt_d = sat_inc32(rd_cnt_q);
      end else begin
         rd_cnt_d = rd_cnt_q;
      end
      if (ram_en_s && ram_we_s) begin
         wr_cnt_d = sat_inc32(wr_cnt_q);
      end else begin
         wr_cnt_d = wr_cnt_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_cnt_q <= 32'd0;
         wr_cnt_q <= 32'd0;
      end else begin
         rd_cnt_q <= rd_cnt_d;
         wr_cnt_q <= wr_cnt_d;
      end
   end

   assign rd_cnt_o = rd_cnt_q;
   assign wr_cnt_o = wr_cnt_q;
`else
   assign rd_cnt_o = 32'd0;
   assign wr_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_dcache_mem_ctrl.sv
// Directed bench for dcache_mem_ctrl: latency, turnaround, latching, wrap, reset abort, LATENCY=1.
module tb_dcache_mem_ctrl;

   localparam int LW = 256;

`ifdef DCACHE_MEM_STATS_EN
   localparam logic [31:0] S = 32'd1;
`else
   localparam logic [31:0] S = 32'd0;
`endif

   localparam logic [LW-1:0] A5    = {32{8'hA5}};
   localparam logic [LW-1:0] D1234 = 256'h1234;
   localparam logic [LW-1:0] P4    = {8{32'hC0DE_0004}};
   localparam logic [LW-1:0] D100  = {8{32'h0100_BEEF}};
   localparam logic [LW-1:0] P7    = {8{32'h7777_0007}};
   localparam logic [LW-1:0] N7    = {8{32'hDEAD_0007}};
   localparam logic [LW-1:0] X48   = {8{32'h4848_4848}};

   logic          clk = 1'b0;
   logic          rst;
   logic          en, wr;
   logic [31:0]   addr;
   logic [LW-1:0] din;
   logic          ack;
   logic [LW-1:0] dout;
   logic [31:0]   rd_cnt, wr_cnt;

   logic          en1, wr1;
   logic [31:0]   addr1;
   logic [LW-1:0] din1;
   logic          ack1;
   logic [LW-1:0] dout1;
   logic [31:0]   rd_cnt1, wr_cnt1;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   dcache_mem_ctrl #(.LATENCY(10)) dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .addr_i   (addr),
      .data_i   (din),
      .enable_i (en),
      .write_i  (wr),
      .ack_o    (ack),
      .data_o   (dout),
      .rd_cnt_o (rd_cnt),
      .wr_cnt_o (wr_cnt)
   );

   dcache_mem_ctrl #(.LATENCY(1)) dut1 (
      .clk_i    (clk),
      .rst_i    (rst),
      .addr_i   (addr1),
      .data_i   (din1),
      .enable_i (en1),
      .write_i  (wr1),
      .ack_o    (ack1),
      .data_o   (dout1),
      .rd_cnt_o (rd_cnt1),
      .wr_cnt_o (wr_cnt1)
   );

   task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // After return we are in "cycle N", just past edge N.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_line(input logic [31:0] a, input logic [LW-1:0] d, input string tag);
      en = 1'b1; wr = 1'b1; addr = a; din = d;
      for (int c = 0; c < 12; c++) begin
         tick();
         if (c == 0) en = 1'b0;
         check($sformatf("%s_ack[%0d]", tag, c), LW'(ack), LW'(c == 10));
      end
   endtask

   task automatic read_line(input logic [31:0] a, input logic [LW-1:0] d, input string tag);
      en = 1'b1; wr = 1'b0; addr = a; din = '0;
      for (int c = 0; c < 12; c++) begin
         tick();
         if (c == 0) en = 1'b0;
         check($sformatf("%s_ack[%0d]", tag, c), LW'(ack), LW'(c == 10));
         if (c == 10) check($sformatf("%s_data", tag), dout, d);
      end
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; wr = 1'b0; addr = 32'd0; din = '0;
      en1 = 1'b0; wr1 = 1'b0; addr1 = 32'd0; din1 = '0;
      tick();
      tick();
      rst = 1'b0;

      check("rst_ack", LW'(ack), LW'(1'b0));
      check("rst_data", dout, '0);
      check("rst_rd_cnt", LW'(rd_cnt), LW'(32'd0));
      check("rst_wr_cnt", LW'(wr_cnt), LW'(32'd0));
      check("rst_ack1", LW'(ack1), LW'(1'b0));

      // Preload line 3; a write ack must not disturb data_o.
      en = 1'b1; wr = 1'b1; addr = 32'h60; din = A5;
      for (int c = 0; c < 12; c++) begin
         tick();
         if (c == 0) en = 1'b0;
         check($sformatf("pre_ack[%0d]", c), LW'(ack), LW'(c == 10));
         if (c == 10) check("pre_data_o", dout, '0);
      end

      // Read with enable held: acks at 10 and 22 (turnaround), data held between.
      en = 1'b1; wr = 1'b0; addr = 32'h60;
      for (int c = 0; c < 24; c++) begin
         tick();
         check($sformatf("hold_ack[%0d]", c), LW'(ack), LW'(c == 10 || c == 22));
         if (c == 10 || c == 22 || c == 15) check($sformatf("hold_data[%0d]", c), dout, A5);
         if (c == 12) en = 1'b0;
      end

      write_line(32'h400, D1234, "w400");
      read_line(32'h400, D1234, "r400");
      check("cnt_rd_3", LW'(rd_cnt), LW'(32'd3 * S));
      check("cnt_wr_2", LW'(wr_cnt), LW'(32'd2 * S));

      // Write-back of line 0x100 then refill of line 4 with enable held high.
      write_line(32'h80, P4, "pre4");
      en = 1'b1; wr = 1'b1; addr = 32'h2000; din = D100;
      for (int c = 0; c < 24; c++) begin
         tick();
         check($sformatf("wb_ack[%0d]", c), LW'(ack), LW'(c == 10 || c == 22));
         if (c == 10) begin
            wr = 1'b0; addr = 32'h80; din = '0;
         end
         if (c == 22) begin
            check("refill_data", dout, P4);
            en = 1'b0;
         end
      end
      read_line(32'h2000, D100, "r100");

      read_line(32'h8000_0060, A5, "wrap");

      // Inputs changed during BUSY must be ignored.
      en = 1'b1; wr = 1'b1; addr = 32'h600; din = X48;
      for (int c = 0; c < 12; c++) begin
         tick();
         if (c == 0) en = 1'b0;
         if (c == 3) begin
            addr = 32'h60; wr = 1'b0; din = '0;
         end
         check($sformatf("latch_ack[%0d]", c), LW'(ack), LW'(c == 10));
      end
      read_line(32'h600, X48, "latch_r48");
      read_line(32'h60, A5, "latch_r3");

      // Reset during a write to line 7 aborts it.
      write_line(32'hE0, P7, "pre7");
      en = 1'b1; wr = 1'b1; addr = 32'hE0; din = N7;
      for (int c = 0; c < 15; c++) begin
         tick();
         if (c == 0) en = 1'b0;
         if (c == 5) rst = 1'b1;
         if (c == 6) rst = 1'b0;
         check($sformatf("abort_ack[%0d]", c), LW'(ack), LW'(1'b0));
      end
      check("abort_data_o", dout, '0);
      check("abort_rd_cnt", LW'(rd_cnt), LW'(32'd0));
      check("abort_wr_cnt", LW'(wr_cnt), LW'(32'd0));
      read_line(32'hE0, P7, "r7");
      check("post_rd_cnt", LW'(rd_cnt), LW'(S));
      check("post_wr_cnt", LW'(wr_cnt), LW'(32'd0));

      // LATENCY=1: ack one cycle after acceptance, next acceptance at cycle 3.
      en1 = 1'b1; wr1 = 1'b1; addr1 = 32'h40; din1 = P4;
      for (int c = 0; c < 6; c++) begin
         tick();
         check($sformatf("l1_ack[%0d]", c), LW'(ack1), LW'(c == 1 || c == 4));
         if (c == 1) begin
            addr1 = 32'h60; din1 = D100;
         end
         if (c == 3) en1 = 1'b0;
      end
      en1 = 1'b1; wr1 = 1'b0; addr1 = 32'h40;
      for (int c = 0; c < 3; c++) begin
         tick();
         if (c == 0) en1 = 1'b0;
         check($sformatf("l1_rd_ack[%0d]", c), LW'(ack1), LW'(c == 1));
         if (c == 1) check("l1_rd_data40", dout1, P4);
      end
      en1 = 1'b1; addr1 = 32'h60;
      for (int c = 0; c < 3; c++) begin
         tick();
         if (c == 0) en1 = 1'b0;
         if (c == 1) check("l1_rd_data60", dout1, D100);
      end
      check("l1_rd_cnt", LW'(rd_cnt1), LW'(32'd2 * S));
      check("l1_wr_cnt", LW'(wr_cnt1), LW'(32'd2 * S));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
